// File: rtl/vga_sync_decoder.sv
// VGA timing receiver: recovers pixel X/Y from active-low hsync/vsync and reports lock.
// Optional VGA_DEC_ERR_CNT_EN adds err_cnt_o, a saturating count of lock losses.
//   state   | meaning
//   SEARCH  | waiting for any hsync falling edge
//   H_TRACK | counting consecutive good lines
//   V_TRACK | lines good; measuring one vsync-to-vsync frame
//   LOCKED  | line and frame periods verified
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_VISIBLE   = 640,
  parameter int V_VISIBLE   = 480,
  parameter int HSYNC_START = 656,
  parameter int VSYNC_START = 490,
  parameter int LOCK_LINES  = 4,
  parameter int X_POS_W     = $clog2(H_TOTAL),
  parameter int Y_POS_W     = $clog2(V_TOTAL)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               px_en_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  output logic [X_POS_W-1:0] pixel_x_o,
  output logic [Y_POS_W-1:0] pixel_y_o,
  output logic               visible_range_o,
  output logic               frame_start_o,
  output logic               locked_o,
  output logic               err_o
`ifdef VGA_DEC_ERR_CNT_EN
  ,
  output logic [15:0]        err_cnt_o
`endif
);

  localparam int LW = $clog2(H_TOTAL + 2);
  localparam int FW = $clog2(V_TOTAL + 2);
  localparam int GW = $clog2(LOCK_LINES + 1);

  localparam logic [X_POS_W-1:0] X_LAST = X_POS_W'(H_TOTAL - 1);
  localparam logic [X_POS_W-1:0] X_HS   = X_POS_W'(HSYNC_START);
  localparam logic [X_POS_W-1:0] X_VIS  = X_POS_W'(H_VISIBLE);
  localparam logic [Y_POS_W-1:0] Y_LAST = Y_POS_W'(V_TOTAL - 1);
  localparam logic [Y_POS_W-1:0] Y_VS   = Y_POS_W'(VSYNC_START);
  localparam logic [Y_POS_W-1:0] Y_VIS  = Y_POS_W'(V_VISIBLE);
  localparam logic [LW-1:0]      L_TOT  = LW'(H_TOTAL);
  localparam logic [LW-1:0]      L_TMO  = LW'(H_TOTAL + 1);
  localparam logic [FW-1:0]      F_TOT  = FW'(V_TOTAL);
  localparam logic [GW-1:0]      G_LAST = GW'(LOCK_LINES - 1);

  typedef enum logic [1:0] {SEARCH, H_TRACK, V_TRACK, LOCKED} state_e;

  state_e             state_q, state_d;
  logic               hs_q, hs_d, vs_q, vs_d;
  logic [X_POS_W-1:0] x_q, x_d;
  logic [Y_POS_W-1:0] y_q, y_d;
  logic [LW-1:0]      line_q, line_d, line_inc;
  logic [FW-1:0]      frame_q, frame_d;
  logic [GW-1:0]      good_q, good_d;
  logic               armed_q, armed_d;
  logic               vis_q, vis_d, fs_q, fs_d, err_q, err_d;
  logic               h_edge, v_edge, line_good, line_bad, frame_good, frame_bad;

  always_comb begin
    state_d    = state_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    x_d        = x_q;
    y_d        = y_q;
    line_d     = line_q;
    frame_d    = frame_q;
    good_d     = good_q;
    armed_d    = armed_q;
    vis_d      = vis_q;
    fs_d       = 1'b0;
    err_d      = 1'b0;
    h_edge     = px_en_i & hs_q & ~hsync_i;
    v_edge     = px_en_i & vs_q & ~vsync_i;
    line_inc   = line_q + 1'b1;
    line_good  = 1'b0;
    line_bad   = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;

    if (px_en_i) begin
      hs_d = hsync_i;
      vs_d = vsync_i;

      if (h_edge)              x_d = X_HS;
      else if (x_q == X_LAST)  x_d = '0;
      else                     x_d = x_q + 1'b1;

      if (v_edge)                          y_d = Y_VS;
      else if (!h_edge && x_q == X_LAST)   y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;

      if (h_edge) begin
        line_good = (line_inc == L_TOT);
        line_bad  = ~line_good;
        line_d    = '0;
      end else if (line_inc == L_TMO) begin
        line_bad = 1'b1;
        line_d   = '0;
      end else begin
        line_d = line_inc;
      end

      // frame_q counts hsync edges since the last vsync edge
      if (v_edge) begin
        frame_good = (frame_q == F_TOT);
        frame_bad  = ~frame_good;
        frame_d    = FW'(h_edge);
      end else if (h_edge) begin
        if (frame_q == F_TOT) begin
          frame_bad = 1'b1;
          frame_d   = '0;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end

      case (state_q)
        SEARCH: begin
          if (h_edge) begin
            state_d = H_TRACK;
            good_d  = '0;
          end
        end
        H_TRACK: begin
          if (line_bad) state_d = SEARCH;
          else if (line_good) begin
            if (good_q == G_LAST) begin
              state_d = V_TRACK;
              armed_d = 1'b0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end
        end
        V_TRACK: begin
          if (line_bad) state_d = SEARCH;
          else if (v_edge) begin
            if (armed_q && frame_good) state_d = LOCKED;
            else                       armed_d = 1'b1;
          end else if (frame_bad) begin
            armed_d = 1'b0;
          end
        end
        LOCKED: begin
          if (line_bad || frame_bad) state_d = SEARCH;
        end
        default: state_d = SEARCH;
      endcase

      vis_d = (state_d == LOCKED) && (x_d < X_VIS) && (y_d < Y_VIS);
      fs_d  = (state_d == LOCKED) && (x_d == '0) && (y_d == '0);
      err_d = (state_q == LOCKED) && (state_d != LOCKED);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEARCH;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      x_q     <= '0;
      y_q     <= '0;
      line_q  <= '0;
      frame_q <= '0;
      good_q  <= '0;
      armed_q <= 1'b0;
      vis_q   <= 1'b0;
      fs_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      x_q     <= x_d;
      y_q     <= y_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      good_q  <= good_d;
      armed_q <= armed_d;
      vis_q   <= vis_d;
      fs_q    <= fs_d;
      err_q   <= err_d;
    end
  end

  assign pixel_x_o       = x_q;
  assign pixel_y_o       = y_q;
  assign visible_range_o = vis_q;
  assign frame_start_o   = fs_q;
  assign locked_o        = (state_q == LOCKED);
  assign err_o           = err_q;

`ifdef VGA_DEC_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 10x8 timing so that lock/relock fits a short run.
module tb_vga_sync_decoder;
  localparam int HT = 10, VT = 8, HV = 6, VV = 5, HS = 7, VS = 6;

  logic clk = 1'b0, rst = 1'b0, px_en = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [3:0] pixel_x;
  logic [2:0] pixel_y;
  logic       vis, fs, locked, err;
`ifdef VGA_DEC_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int total = 0, bad = 0;
  int gx = 0, gy = 0;
  bit short_line = 0, hs_stuck = 0;
  int smp_x, smp_y, cx, cy;
  logic cur_lock = 1'b0, cur_err, cur_fs, cur_vis;
  int fs_cnt = 0, err_seen = 0;

  typedef struct {
    logic px, hs, vs;
    int   ex, ey;
  } vec_t;
  vec_t vec[9];

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_VISIBLE(HV), .V_VISIBLE(VV),
    .HSYNC_START(HS), .VSYNC_START(VS), .LOCK_LINES(4), .X_POS_W(4), .Y_POS_W(3)
  ) dut (
    .clk_i(clk), .rst_i(rst), .px_en_i(px_en), .hsync_i(hsync), .vsync_i(vsync),
    .pixel_x_o(pixel_x), .pixel_y_o(pixel_y), .visible_range_o(vis),
    .frame_start_o(fs), .locked_o(locked), .err_o(err)
`ifdef VGA_DEC_ERR_CNT_EN
    , .err_cnt_o(err_cnt)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    px_en = 1'b0;
    @(posedge clk); #1;
    chk("rst_x", int'(pixel_x), 0);
    chk("rst_y", int'(pixel_y), 0);
    chk("rst_vis", int'(vis), 0);
    chk("rst_fs", int'(fs), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    cur_lock = 1'b0;
  endtask

  // one generator pixel: px_en pulse then three idle clocks
  task automatic step_px();
    @(negedge clk);
    hsync = hs_stuck ? 1'b1 : !(gx >= HS && gx < HS + 2);
    vsync = !(gy >= VS && gy < VS + 2);
    px_en = 1'b1;
    smp_x = gx;
    smp_y = gy;
    @(posedge clk); #1;
    cx = int'(pixel_x); cy = int'(pixel_y);
    cur_lock = locked; cur_err = err; cur_fs = fs; cur_vis = vis;
    fs_cnt += int'(fs);
    err_seen += int'(err);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      px_en = 1'b0;
      @(posedge clk); #1;
      fs_cnt += int'(fs);
      err_seen += int'(err);
    end
    if (gx == (short_line ? HT - 2 : HT - 1)) begin
      gx = 0;
      short_line = 0;
      gy = (gy == VT - 1) ? 0 : gy + 1;
    end else begin
      gx++;
    end
  endtask

  task automatic run_to(input int tx, input int ty);
    int n = 0;
    while (!(gx == tx && gy == ty) && n < 200) begin
      step_px();
      n++;
    end
  endtask

  task automatic wait_lock(input string name);
    int n = 0;
    while (!cur_lock && n < 400) begin
      step_px();
      n++;
    end
    chk(name, int'(cur_lock), 1);
    step_px();
    chk({name, "_x"}, cx, smp_x);
    chk({name, "_y"}, cy, smp_y);
  endtask

  // shorten line 1 by one pixel; the early hsync edge must drop lock once
  task automatic short_loss(input string name);
    int at = -1;
    run_to(0, 1);
    short_line = 1;
    err_seen = 0;
    for (int n = 0; n < 30 && at < 0; n++) begin
      step_px();
      if (cur_err) at = n;
    end
    chk({name, "_err_when"}, at, 16);
    chk({name, "_unlock"}, int'(cur_lock), 0);
    repeat (3) step_px();
    chk({name, "_err_once"}, err_seen, 1);
  endtask

  initial begin
    int mism, vis_mism, vis_cnt;
    bit lock_seen;

    vec[0] = '{1'b1, 1'b1, 1'b1, 1, 0};
    vec[1] = '{1'b0, 1'b0, 1'b1, 1, 0};
    vec[2] = '{1'b1, 1'b0, 1'b1, 7, 0};
    vec[3] = '{1'b1, 1'b0, 1'b1, 8, 0};
    vec[4] = '{1'b1, 1'b1, 1'b1, 9, 0};
    vec[5] = '{1'b1, 1'b1, 1'b1, 0, 1};
    vec[6] = '{1'b1, 1'b1, 1'b0, 1, 6};
    vec[7] = '{1'b1, 1'b1, 1'b0, 2, 6};
    vec[8] = '{1'b1, 1'b0, 1'b1, 7, 6};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      px_en = vec[i].px;
      hsync = vec[i].hs;
      vsync = vec[i].vs;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_x", i), int'(pixel_x), vec[i].ex);
      chk($sformatf("vec%0d_y", i), int'(pixel_y), vec[i].ey);
      chk($sformatf("vec%0d_locked", i), int'(locked), 0);
    end

    hsync = 1'b1;
    vsync = 1'b1;
    do_reset();
    gx = 0; gy = 0;
    err_seen = 0;
    lock_seen = 0;
    for (int i = 0; i < 140; i++) begin
      step_px();
      lock_seen |= cur_lock;
    end
    chk("no_early_lock", int'(lock_seen), 0);
    step_px();
    chk("lock_at_2nd_vsync", int'(cur_lock), 1);
    chk("lock_x", cx, smp_x);
    chk("lock_y", cy, smp_y);
    chk("no_err_before_lock", err_seen, 0);

    fs_cnt = 0; vis_cnt = 0; mism = 0; vis_mism = 0;
    for (int i = 0; i < HT * VT; i++) begin
      step_px();
      if (cx != smp_x || cy != smp_y) mism++;
      if (int'(cur_vis) != int'(smp_x < HV && smp_y < VV)) vis_mism++;
      vis_cnt += int'(cur_vis);
    end
    chk("frame_xy_mismatches", mism, 0);
    chk("frame_vis_mismatches", vis_mism, 0);
    chk("frame_vis_count", vis_cnt, HV * VV);
    chk("frame_start_count", fs_cnt, 1);
    chk("steady_no_err", err_seen, 0);

    short_loss("short1");
    wait_lock("relock_short");

    run_to(HS, 0);
    step_px();
    hs_stuck = 1;
    err_seen = 0;
    repeat (10) step_px();
    chk("stuck_no_err_early", err_seen, 0);
    chk("stuck_still_locked", int'(cur_lock), 1);
    step_px();
    chk("stuck_err_at_timeout", int'(cur_err), 1);
    chk("stuck_unlock", int'(cur_lock), 0);
    repeat (12) step_px();
    chk("stuck_single_err", err_seen, 1);
    chk("stuck_stays_unlocked", int'(cur_lock), 0);
    hs_stuck = 0;
    wait_lock("relock_stuck");

    short_loss("short2");
`ifdef VGA_DEC_ERR_CNT_EN
    chk("err_cnt_three", int'(err_cnt), 3);
`endif
    wait_lock("relock_short2");

    run_to(4, 3);
    do_reset();
    lock_seen = 0;
    for (int i = 0; i < 60; i++) begin
      step_px();
      lock_seen |= cur_lock;
    end
    chk("rst_no_quick_relock", int'(lock_seen), 0);
    wait_lock("relock_rst");
`ifdef VGA_DEC_ERR_CNT_EN
    chk("err_cnt_cleared", int'(err_cnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
